fmc_initiator: RTL

- Synchronous FMC bus initiator for single-beat transactions; the controller end of the FMC protocol whose data pins pass through the FMC D-port IO buffers.
- Used for FPGA-side loopback/self-test and as a bus-functional master against the FMC slave logic.
- Takes host requests on a valid/ready interface and generates fmc_clk, NE, NL, NOE, NWE and address.
- Drives or samples the D bus via the PHY tri-state interface, honours NWAIT and returns read data or a timeout error.

---
 rtl/fmc_initiator.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fmc_initiator.sv
// ---------------------------------------------------------------------------
// fmc_initiator
//
// Single-beat FMC bus initiator. A host request arriving on a valid/ready
// handshake is turned into one FMC transaction:
//   ADDR -> LAT -> WAIT -> DATA -> END
// The data pins are driven and sampled through the D-port tri-state PHY.
// The bus clock fmc_clk runs at clk/2.
//   - Bus outputs change only on the clk edge that drives fmc_clk low
//     (fall phase).
//   - fmc_nwait and d_in are sampled only on the clk edge that drives
//     fmc_clk high (rise phase).
//
// Ports
//   clk, rst                  system clock, async active-high reset
//   req_valid/req_ready       host request handshake
//   req_write                 1 = write, 0 = read
//   req_addr, req_wdata       transaction address / write data
//   rsp_valid                 one-clk completion pulse
//   rsp_rdata                 last successful read data (held)
//   rsp_error                 NWAIT timeout, qualified by rsp_valid
//   fmc_clk, fmc_a            bus clock and address
//   fmc_ne, fmc_nl            chip enable / address valid (active low)
//   fmc_noe, fmc_nwe          output enable / write enable (active low)
//   fmc_nwait                 slave wait request (active low, pre-synchronised)
//   d_out, d_in, d_t          PHY buf_di / buf_ro / buf_t (d_t=1 -> tri-state)
// ---------------------------------------------------------------------------
module fmc_initiator #(
  parameter int ADDR_WIDTH   = 22,
  parameter int BUS_WIDTH    = 32,
  parameter int DATA_LATENCY = 2,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0]  req_wdata,
  output logic                  rsp_valid,
  output logic [BUS_WIDTH-1:0]  rsp_rdata,
  output logic                  rsp_error,
  output logic                  fmc_clk,
  output logic [ADDR_WIDTH-1:0] fmc_a,
  output logic                  fmc_ne,
  output logic                  fmc_nl,
  output logic                  fmc_noe,
  output logic                  fmc_nwe,
  input  logic                  fmc_nwait,
  output logic [BUS_WIDTH-1:0]  d_out,
  input  logic [BUS_WIDTH-1:0]  d_in,
  output logic                  d_t
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LAT,
    S_WAIT,
    S_DATA,
    S_END
  } state_t;

  // LAT is entered with the counter preloaded to DATA_LATENCY-1 and left
  // when it reaches zero, so the state lasts exactly DATA_LATENCY bus clocks.
  localparam logic [3:0]  LAT_LOAD = (DATA_LATENCY > 0) ? 4'(DATA_LATENCY - 1) : 4'd0;
  localparam logic [15:0] TMO_VAL  = 16'(WAIT_TIMEOUT);

  state_t                  state_q;
  logic                    clk_q;
  logic                    pend_q;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [BUS_WIDTH-1:0]    wdata_q;
  logic [3:0]              lat_cnt_q;
  logic [15:0]             wait_cnt_q;
  logic                    go_data_q;
  logic                    timeout_q;
  logic                    ready_q;
  logic                    rsp_valid_q;
  logic                    rsp_error_q;
  logic [BUS_WIDTH-1:0]    rdata_q;
  logic [ADDR_WIDTH-1:0]   a_q;
  logic                    ne_q;
  logic                    nl_q;
  logic                    noe_q;
  logic                    nwe_q;
  logic [BUS_WIDTH-1:0]    dout_q;
  logic                    dt_q;

  logic rise;
  logic fall;
  logic accept;

  // clk_q is the current level of fmc_clk. The coming edge flips it, so a
  // low level means the next edge is a rise and a high level means a fall.
  assign rise   = ~clk_q;
  assign fall   = clk_q;
  assign accept = req_valid & ready_q;

  // Bus-clock generator, request capture and transaction sequencer. Every
  // bus-visible output is a register, so pins only move on clock edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      clk_q       <= 1'b0;
      pend_q      <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_cnt_q   <= 4'd0;
      wait_cnt_q  <= 16'd0;
      go_data_q   <= 1'b0;
      timeout_q   <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rdata_q     <= '0;
      a_q         <= '0;
      ne_q        <= 1'b1;
      nl_q        <= 1'b1;
      noe_q       <= 1'b1;
      nwe_q       <= 1'b1;
      dout_q      <= '0;
      dt_q        <= 1'b1;
    end else begin
      clk_q       <= ~clk_q;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;

      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        pend_q  <= 1'b1;
        ready_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          // Covers the first cycle after reset; an accept in the same
          // cycle sees ready_q=1 and is not overridden here.
          if (!pend_q && !ready_q) begin
            ready_q <= 1'b1;
          end
          if (fall && pend_q) begin
            pend_q  <= 1'b0;
            state_q <= S_ADDR;
            ne_q    <= 1'b0;
            nl_q    <= 1'b0;
            a_q     <= addr_q;
            dt_q    <= ~wr_q;
            if (wr_q) begin
              dout_q <= wdata_q;
            end
          end
        end

        S_ADDR: begin
          if (fall) begin
            nl_q       <= 1'b1;
            noe_q      <= wr_q;
            nwe_q      <= ~wr_q;
            wait_cnt_q <= 16'd0;
            go_data_q  <= 1'b0;
            timeout_q  <= 1'b0;
            lat_cnt_q  <= LAT_LOAD;
            state_q    <= (DATA_LATENCY == 0) ? S_WAIT : S_LAT;
          end
        end

        S_LAT: begin
          if (fall) begin
            if (lat_cnt_q == 4'd0) begin
              state_q <= S_WAIT;
            end else begin
              lat_cnt_q <= lat_cnt_q - 4'd1;
            end
          end
        end

        S_WAIT: begin
          // NWAIT is judged at the rise; the resulting move happens on the
          // following fall so outputs stay aligned to falling bus edges.
          if (rise) begin
            if (fmc_nwait) begin
              go_data_q <= 1'b1;
            end else begin
              wait_cnt_q <= wait_cnt_q + 16'd1;
              if (wait_cnt_q + 16'd1 == TMO_VAL) begin
                timeout_q <= 1'b1;
              end
            end
          end
          if (fall) begin
            if (go_data_q || timeout_q) begin
              state_q     <= S_END;
              ne_q        <= 1'b1;
              noe_q       <= 1'b1;
              nwe_q       <= 1'b1;
              dt_q        <= 1'b1;
              rsp_valid_q <= 1'b1;
              rsp_error_q <= timeout_q;
              if (go_data_q) begin
                state_q     <= S_DATA;
                ne_q        <= 1'b0;
                noe_q       <= wr_q;
                nwe_q       <= ~wr_q;
                dt_q        <= ~wr_q;
                rsp_valid_q <= 1'b0;
                rsp_error_q <= 1'b0;
              end
            end
          end
        end

        S_DATA: begin
          if (rise && !wr_q) begin
            rdata_q <= d_in;
          end
          if (fall) begin
            state_q     <= S_END;
            ne_q        <= 1'b1;
            noe_q       <= 1'b1;
            nwe_q       <= 1'b1;
            dt_q        <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b0;
          end
        end

        S_END: begin
          // Turnaround bus clock with NE high guarantees separation from
          // the next transaction; fmc_a is intentionally left unchanged.
          if (fall) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rdata_q;
  assign fmc_clk   = clk_q;
  assign fmc_a     = a_q;
  assign fmc_ne    = ne_q;
  assign fmc_nl    = nl_q;
  assign fmc_noe   = noe_q;
  assign fmc_nwe   = nwe_q;
  assign d_out     = dout_q;
  assign d_t       = dt_q;

endmodule
